// File: rtl/reg_entry.sv
`default_nettype none
// ============================================================================
//  Module      : reg_entry
//  Description : One storage slot of the register bank. It holds a WIDTH-bit
//                data word and its valid flag. The slot takes d_i/v_i on any
//                clock edge where load_i is high. Otherwise it keeps its
//                contents. A low rst_ni at the clock edge clears the slot and
//                overrides load_i.
//  Ports       : clk_i   - clock, state changes on the rising edge
//                rst_ni  - synchronous active-low reset
//                load_i  - capture d_i/v_i this edge
//                d_i     - next data word
//                v_i     - next valid flag
//                q_o     - stored data word
//                v_o     - stored valid flag
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] q_o,
    output logic             v_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= d_i;
            valid_q <= v_i;
        end
    end

    assign q_o = data_q;
    assign v_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank
//  Description : A bank of DEPTH entries. Each entry is WIDTH bits wide and
//                has a valid flag. The bank has two registered read ports.
//                Three update operations are available, with this priority:
//                reset, then clear, then shift, then addressed write. Only
//                the highest-priority request acts in a given cycle. The read
//                ports have a bypass: at the clock edge they capture the
//                entry's next-state value, so a write, shift or clear in the
//                same cycle is visible one cycle later.
//  Ports       : CLK     - clock
//                RST_N   - synchronous active-low reset
//                CLR     - clear every entry and valid flag
//                SHIFT   - entry i takes entry i-1; entry 0 takes D (valid)
//                WE      - write D into entry WADDR
//                WADDR   - write address
//                D       - write / shift-in data
//                RADDR0  - read address, port 0
//                RADDR1  - read address, port 1
//                Q0, V0  - registered data / valid, port 0
//                Q1, V1  - registered data / valid, port 1
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             SHIFT,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    RADDR0,
    input  logic [AW-1:0]    RADDR1,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic             V0,
    output logic             V1
);

    // ------------------------------------------------------------------
    // Entry storage: current state (_q) and next state (_d)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ent_q  [DEPTH];
    logic [DEPTH-1:0] ent_v_q;
    logic [WIDTH-1:0] ent_d  [DEPTH];
    logic [DEPTH-1:0] ent_v_d;
    logic [DEPTH-1:0] ent_load;

    // When DEPTH is not a power of two, some addresses have no entry.
    // Such addresses ignore writes and read back as zero.
    logic waddr_ok;
    logic raddr0_ok;
    logic raddr1_ok;

    assign waddr_ok  = (int'(WADDR)  < DEPTH);
    assign raddr0_ok = (int'(RADDR0) < DEPTH);
    assign raddr1_ok = (int'(RADDR1) < DEPTH);

    // ------------------------------------------------------------------
    // Next-state / priority logic. Only the highest-priority operation
    // drives the entries. Reset is handled inside each entry and in the
    // read registers, so it overrides everything computed here.
    // ------------------------------------------------------------------
    always_comb begin
        ent_d    = ent_q;
        ent_v_d  = ent_v_q;
        ent_load = '0;

        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            ent_v_d  = '0;
            ent_load = '1;
        end else if (SHIFT) begin
            ent_d[0]   = D;
            ent_v_d[0] = 1'b1;
            for (int i = 1; i < DEPTH; i++) begin
                ent_d[i]   = ent_q[i-1];
                ent_v_d[i] = ent_v_q[i-1];
            end
            ent_load = '1;
        end else if (WE && waddr_ok) begin
            ent_d[WADDR]    = D;
            ent_v_d[WADDR]  = 1'b1;
            ent_load[WADDR] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Entry instances
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            reg_entry #(
                .WIDTH (WIDTH)
            ) u_entry (
                .clk_i  (CLK),
                .rst_ni (RST_N),
                .load_i (ent_load[gi]),
                .d_i    (ent_d[gi]),
                .v_i    (ent_v_d[gi]),
                .q_o    (ent_q[gi]),
                .v_o    (ent_v_q[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports. Each port selects from the next-state view of the
    // entries, which gives the write-first bypass.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q0_d, q1_d;
    logic             v0_d, v1_d;
    logic [WIDTH-1:0] q0_q, q1_q;
    logic             v0_q, v1_q;

    always_comb begin
        q0_d = '0;
        v0_d = 1'b0;
        q1_d = '0;
        v1_d = 1'b0;
        if (raddr0_ok) begin
            q0_d = ent_d[RADDR0];
            v0_d = ent_v_d[RADDR0];
        end
        if (raddr1_ok) begin
            q1_d = ent_d[RADDR1];
            v1_d = ent_v_d[RADDR1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q0_q <= '0;
            v0_q <= 1'b0;
            q1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            q0_q <= q0_d;
            v0_q <= v0_d;
            q1_q <= q1_d;
            v1_q <= v1_d;
        end
    end

    assign Q0 = q0_q;
    assign V0 = v0_q;
    assign Q1 = q1_q;
    assign V1 = v1_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bank
//  Description : Self-checking bench for reg_bank. One instance uses
//                DEPTH=4 and a second uses DEPTH=3; both get the same
//                stimulus. A reference model predicts the read outputs of
//                both instances whenever inputs are driven. The prediction is
//                pushed to a queue and compared after the clock edge.
//                Directed scenarios also compare against fixed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n, clr, shift, we;
    logic [1:0] waddr, ra0, ra1;
    logic [7:0] d;

    logic [7:0] q0, q1, r0, r1;
    logic       v0, v1, w0, w1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr), .SHIFT(shift), .WE(we),
        .WADDR(waddr), .D(d), .RADDR0(ra0), .RADDR1(ra1),
        .Q0(q0), .Q1(q1), .V0(v0), .V1(v1)
    );

    reg_bank #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr), .SHIFT(shift), .WE(we),
        .WADDR(waddr), .D(d), .RADDR0(ra0), .RADDR1(ra1),
        .Q0(r0), .Q1(r1), .V0(w0), .V1(w1)
    );

    // Reference model: index 0 models DEPTH=4, index 1 models DEPTH=3
    logic [7:0] md [2][4];
    logic       mv [2][4];
    int         dep [2] = '{4, 3};

    // Each element is {valid, data}: a* for the DEPTH=4 bank, b* for DEPTH=3
    typedef struct {
        logic [8:0] a0, a1, b0, b1;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_rd(input int k, input logic [1:0] a);
        if (int'(a) >= dep[k]) return 9'h000;
        return {mv[k][a], md[k][a]};
    endfunction

    // Advance the model for the inputs being driven, queue the predicted
    // read outputs, clock once, then compare against the queue head.
    task automatic tick();
        exp_t e, g;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clr) begin
                for (int j = 0; j < 4; j++) begin
                    md[k][j] = 8'h00;
                    mv[k][j] = 1'b0;
                end
            end else if (shift) begin
                for (int j = dep[k] - 1; j > 0; j--) begin
                    md[k][j] = md[k][j-1];
                    mv[k][j] = mv[k][j-1];
                end
                md[k][0] = d;
                mv[k][0] = 1'b1;
            end else if (we && int'(waddr) < dep[k]) begin
                md[k][waddr] = d;
                mv[k][waddr] = 1'b1;
            end
        end
        if (!rst_n) begin
            e.a0 = '0; e.a1 = '0; e.b0 = '0; e.b1 = '0;
        end else begin
            e.a0 = model_rd(0, ra0);
            e.a1 = model_rd(0, ra1);
            e.b0 = model_rd(1, ra0);
            e.b1 = model_rd(1, ra1);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            g = sb.pop_front();
            chk("d4_q0", {24'h0, q0}, {24'h0, g.a0[7:0]});
            chk("d4_v0", {31'h0, v0}, {31'h0, g.a0[8]});
            chk("d4_q1", {24'h0, q1}, {24'h0, g.a1[7:0]});
            chk("d4_v1", {31'h0, v1}, {31'h0, g.a1[8]});
            chk("d3_q0", {24'h0, r0}, {24'h0, g.b0[7:0]});
            chk("d3_v0", {31'h0, w0}, {31'h0, g.b0[8]});
            chk("d3_q1", {24'h0, r1}, {24'h0, g.b1[7:0]});
            chk("d3_v1", {31'h0, w1}, {31'h0, g.b1[8]});
        end
    endtask

    task automatic idle();
        clr = 1'b0; shift = 1'b0; we = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 4; j++) begin
                md[k][j] = 8'h00;
                mv[k][j] = 1'b0;
            end
        rst_n = 1'b0; clr = 1'b0; shift = 1'b0; we = 1'b0;
        waddr = 2'd0; d = 8'h00; ra0 = 2'd0; ra1 = 2'd0;

        // Reset held for two cycles while a write is requested
        we = 1'b1; waddr = 2'd2; d = 8'hA5; ra0 = 2'd2; ra1 = 2'd0;
        tick();
        tick();
        chk("rst_q0", {24'h0, q0}, 32'h00);
        chk("rst_v0", {31'h0, v0}, 32'h0);

        // Leave reset: the write lands and is bypassed to port 0.
        // Port 1 reads entry 0, which has never been written.
        rst_n = 1'b1;
        tick();
        chk("wr_q0", {24'h0, q0}, 32'hA5);
        chk("wr_v0", {31'h0, v0}, 32'h1);
        chk("unwr_q1", {24'h0, q1}, 32'h00);
        chk("unwr_v1", {31'h0, v1}, 32'h0);

        // Same-cycle write and read on port 1
        we = 1'b1; waddr = 2'd1; d = 8'h3C; ra1 = 2'd1;
        tick();
        chk("byp_q1", {24'h0, q1}, 32'h3C);
        chk("byp_v1", {31'h0, v1}, 32'h1);

        // Five shifts; the first value falls off the end
        idle(); shift = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            tick();
        end
        idle();
        ra0 = 2'd0; ra1 = 2'd1;
        tick();
        chk("sh_e0", {24'h0, q0}, 32'h05);
        chk("sh_e1", {24'h0, q1}, 32'h04);
        ra0 = 2'd2; ra1 = 2'd3;
        tick();
        chk("sh_e2", {24'h0, q0}, 32'h03);
        chk("sh_e3", {24'h0, q1}, 32'h02);
        chk("sh_v2", {31'h0, v0}, 32'h1);
        chk("sh_v3", {31'h0, v1}, 32'h1);

        // Clear wins over shift and write
        clr = 1'b1; shift = 1'b1; we = 1'b1; waddr = 2'd0; d = 8'hEE;
        ra0 = 2'd0; ra1 = 2'd3;
        tick();
        chk("pri_clr_q0", {24'h0, q0}, 32'h00);
        chk("pri_clr_v0", {31'h0, v0}, 32'h0);
        chk("pri_clr_v1", {31'h0, v1}, 32'h0);

        // Load entry 2. Then shift wins over a write to entry 3.
        idle(); we = 1'b1; waddr = 2'd2; d = 8'h77;
        tick();
        idle(); shift = 1'b1; we = 1'b1; waddr = 2'd3; d = 8'h99;
        ra0 = 2'd0; ra1 = 2'd3;
        tick();
        chk("pri_sh_e3", {24'h0, q1}, 32'h77);
        chk("pri_sh_e0", {24'h0, q0}, 32'h99);

        // Out-of-range write and read on the DEPTH=3 bank
        idle(); we = 1'b1; waddr = 2'd3; d = 8'hFF; ra0 = 2'd3; ra1 = 2'd0;
        tick();
        chk("oor_q0", {24'h0, r0}, 32'h00);
        chk("oor_v0", {31'h0, w0}, 32'h0);
        idle();
        for (int a = 0; a < 3; a++) begin
            ra0 = 2'(a); ra1 = 2'(a);
            tick();
        end

        // Reset in the middle of activity discards the operations
        shift = 1'b1; we = 1'b1; d = 8'h5A; waddr = 2'd1; rst_n = 1'b0;
        tick();
        chk("mid_rst_q0", {24'h0, q0}, 32'h00);
        rst_n = 1'b1; idle(); ra0 = 2'd0; ra1 = 2'd1;
        tick();
        chk("post_rst_v0", {31'h0, v0}, 32'h0);

        // Random mix of operations
        for (int n = 0; n < 60; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            clr   = ($urandom_range(0, 19) == 0);
            shift = ($urandom_range(0, 3) == 0);
            we    = ($urandom_range(0, 1) == 1);
            waddr = 2'($urandom_range(0, 3));
            d     = 8'($urandom_range(0, 255));
            ra0   = 2'($urandom_range(0, 3));
            ra1   = 2'($urandom_range(0, 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
